// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - op codes, controller state encoding and product half select
package mul_pkg;

  localparam logic [1:0] MUL_W   = 2'b00;
  localparam logic [1:0] MULH_W  = 2'b01;
  localparam logic [1:0] MULH_WU = 2'b10;

  localparam int HALF_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  // Only the two MULH forms want the high half; the reserved code falls in with MUL_W.
  function automatic logic [HALF_W-1:0] sel_half(input logic [1:0] code,
                                                  input logic [2*HALF_W-1:0] prod);
    return ((code == MULH_W) || (code == MULH_WU)) ? prod[2*HALF_W-1:HALF_W]
                                                   : prod[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/mul_reuse_tag.sv
// rtl/mul_reuse_tag.sv - operand/signedness tag of the last captured product and hit compare
module mul_reuse_tag #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            upd,
  input  logic [XLEN-1:0] upd_src1,
  input  logic [XLEN-1:0] upd_src2,
  input  logic            upd_signed,
  input  logic [XLEN-1:0] cmp_src1,
  input  logic [XLEN-1:0] cmp_src2,
  input  logic            cmp_signed,
  output logic            hit
);

  logic [XLEN-1:0] tag_src1_q;
  logic [XLEN-1:0] tag_src2_q;
  logic            tag_signed_q;
  logic            tag_valid_q;

  // Only reset invalidates the tag; the stored product stays correct across flushes.
  always_ff @(posedge clk) begin
    if (rstn) begin
      tag_src1_q   <= '0;
      tag_src2_q   <= '0;
      tag_signed_q <= 1'b0;
      tag_valid_q  <= 1'b0;
    end else if (upd) begin
      tag_src1_q   <= upd_src1;
      tag_src2_q   <= upd_src2;
      tag_signed_q <= upd_signed;
      tag_valid_q  <= 1'b1;
    end
  end

  assign hit = tag_valid_q && (tag_src1_q == cmp_src1) && (tag_src2_q == cmp_src2)
               && (tag_signed_q == cmp_signed);

endmodule

// File: rtl/mul_ex_ctrl.sv
// rtl/mul_ex_ctrl.sv - multiplier execute-stage controller; MUL_REUSE_EN enables product reuse
module mul_ex_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_code,
  input  logic [XLEN-1:0] op_src1,
  input  logic [XLEN-1:0] op_src2,
  input  logic [RD_W-1:0] op_rd,
  input  logic            flush,
  output logic            mul_start,
  output logic            mul_signed,
  output logic [XLEN-1:0] mul_reg1,
  output logic [XLEN-1:0] mul_reg2,
  input  logic            mul_done,
  input  logic [64:0]     mul_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [RD_W-1:0] rd_q;
  logic [1:0]      code_q;
  logic            signed_q;
  logic [63:0]     prod_q;
  logic            op_signed;
  logic            accept;
  logic            capture;
  logic            hit;
  logic            unused_result_msb;

  assign unused_result_msb = mul_result[64];
  assign op_signed         = (op_code != MULH_WU);
  assign accept            = op_valid && op_ready && !flush;

`ifdef MUL_REUSE_EN
  // A drained result is still a valid product for its operands, so it refreshes the tag too.
  assign capture = mul_done && ((state_q == S_WAIT) || (state_q == S_DRAIN));

  mul_reuse_tag #(.XLEN(XLEN)) u_tag (
    .clk        (clk),
    .rstn       (rstn),
    .upd        (capture),
    .upd_src1   (src1_q),
    .upd_src2   (src2_q),
    .upd_signed (signed_q),
    .cmp_src1   (op_src1),
    .cmp_src2   (op_src2),
    .cmp_signed (op_signed),
    .hit        (hit)
  );
`else
  assign capture = mul_done && (state_q == S_WAIT) && !flush;
  assign hit     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = hit ? S_HOLD : S_LAUNCH;
      S_LAUNCH: state_d = flush ? S_IDLE : S_WAIT;
      // A done arriving with the flush is the one DRAIN would wait for, so skip DRAIN.
      S_WAIT: begin
        if (flush)         state_d = mul_done ? S_IDLE : S_DRAIN;
        else if (mul_done) state_d = S_HOLD;
      end
      S_HOLD:   if (flush || wb_ready) state_d = S_IDLE;
      S_DRAIN:  if (mul_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= S_IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      rd_q     <= '0;
      code_q   <= MUL_W;
      signed_q <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src1_q   <= op_src1;
        src2_q   <= op_src2;
        rd_q     <= op_rd;
        code_q   <= op_code;
        signed_q <= op_signed;
      end
      if (capture) prod_q <= mul_result[63:0];
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks before the first edge.
  assign op_ready   = !rstn && (state_q == S_IDLE);
  assign busy       = !rstn && (state_q != S_IDLE);
  assign mul_start  = !rstn && (state_q == S_LAUNCH) && !flush;
  assign wb_valid   = !rstn && (state_q == S_HOLD) && !flush;
  assign mul_signed = signed_q;
  assign mul_reg1   = src1_q;
  assign mul_reg2   = src2_q;
  assign wb_rd      = rd_q;
  assign wb_data    = sel_half(code_q, prod_q);

endmodule

// File: tb/tb_mul_ex_ctrl.sv
// tb/tb_mul_ex_ctrl.sv - scoreboard bench for mul_ex_ctrl with a behavioural multiplier
module tb_mul_ex_ctrl;

  localparam logic [1:0] C_MUL_W   = 2'b00;
  localparam logic [1:0] C_MULH_W  = 2'b01;
  localparam logic [1:0] C_MULH_WU = 2'b10;
`ifdef MUL_REUSE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_src1 = '0;
  logic [31:0] op_src2 = '0;
  logic [4:0]  op_rd = '0;
  logic        flush = 1'b0;
  logic        mul_start, mul_signed;
  logic [31:0] mul_reg1, mul_reg2;
  logic        mul_done = 1'b0;
  logic [64:0] mul_result = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        busy;

  mul_ex_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_src1(op_src1), .op_src2(op_src2), .op_rd(op_rd), .flush(flush),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_reg1(mul_reg1), .mul_reg2(mul_reg2),
    .mul_done(mul_done), .mul_result(mul_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          wb_cnt = 0;
  int          mul_lat = 1;
  int          pend = 0;
  logic [63:0] pend_res = '0;
  bit          in_valid = 1'b0;
  int          first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Multiplier model: result computed from the operands seen with mul_start.
  always @(negedge clk) begin
    if (mul_start) begin
      start_cnt++;
      pend = mul_lat;
      if (mul_signed)
        pend_res = $signed({{32{mul_reg1[31]}}, mul_reg1}) * $signed({{32{mul_reg2[31]}}, mul_reg2});
      else
        pend_res = {32'b0, mul_reg1} * {32'b0, mul_reg2};
    end
  end

  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mul_done   = 1'b1;
        mul_result = {1'b0, pend_res};
      end
    end
  end

  // Monitor: pops the scoreboard on every writeback handshake.
  always @(negedge clk) begin
    exp_t e;
    if (wb_valid) begin
      if (!in_valid) begin
        in_valid  = 1'b1;
        first_cyc = cyc;
        wb_cnt++;
      end
      if (wb_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got rd %0d data 0x%0h, expected no writeback", wb_rd, wb_data);
        end else begin
          e = sb.pop_front();
          chk("wb_data", 64'(wb_data), 64'(e.data));
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("wb_latency", 64'(first_cyc - e.acc + 1), 64'(e.lat));
        end
        in_valid = 1'b0;
      end
    end else begin
      in_valid = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: op_ready 0, expected 1");
      return;
    end
    op_valid = 1'b1;
    op_code  = code;
    op_src1  = a;
    op_src2  = b;
    op_rd    = rd;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    if (push) begin
      e.data = exp;
      e.rd   = rd;
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: pending %0d busy %0d, expected 0 0", name, sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic wait_wb_valid(input string name);
    int n;
    n = 0;
    while (!wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(wb_valid), 64'd1);
  endtask

  initial begin
    int s0, w0, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_mul_reg1", 64'(mul_reg1), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("post_rst_op_ready", 64'(op_ready), 64'd1);

    wb_ready = 1'b1;
    issue(C_MUL_W,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, 32'h00000001, 3);
    issue(C_MULH_W,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1, 32'h00000000, HIT_LAT);
    issue(C_MULH_WU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, 32'hFFFFFFFE, 3);
    wait_done("ones");
    issue(C_MULH_W,  32'h80000000, 32'h00000002, 5'd4, 1'b1, 32'hFFFFFFFF, 3);
    issue(C_MULH_WU, 32'h80000000, 32'h00000002, 5'd5, 1'b1, 32'h00000001, 3);
    wait_done("minint");

    issue(2'b11, 32'd3, 32'd5, 5'd6, 1'b1, 32'd15, 3);
    @(negedge clk);
    chk("rsvd_signed", 64'(mul_signed), 64'd1);
    chk("rsvd_reg1", 64'(mul_reg1), 64'd3);
    wait_done("reserved");

    wb_ready = 1'b0;
    issue(C_MUL_W, 32'd6, 32'd7, 5'd9, 1'b1, 32'd42, 3);
    wait_wb_valid("stall_valid_seen");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(wb_valid), 64'd1);
      chk("stall_data", 64'(wb_data), 64'd42);
      chk("stall_rd", 64'(wb_rd), 64'd9);
      chk("stall_op_ready", 64'(op_ready), 64'd0);
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    wait_done("stall");
    chk("stall_retired_ready", 64'(op_ready), 64'd1);

    s0 = start_cnt;
    issue(C_MUL_W, 32'd4, 32'd4, 5'd1, 1'b0, 32'd0, 0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_launch_start", 64'(mul_start), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_launch_idle", 64'(busy), 64'd0);
    chk("flush_launch_nstart", 64'(start_cnt - s0), 64'd0);

    @(posedge clk);
    #1;
    op_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_accept", 64'(busy), 64'd0);

    mul_lat = 3;
    w0 = wb_cnt;
    issue(C_MULH_W, 32'd5, 32'd5, 5'd2, 1'b0, 32'd0, 0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_op_ready", 64'(op_ready), 64'd0);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_exit", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    chk("drain_no_wb", 64'(wb_cnt - w0), 64'd0);
    mul_lat = 1;
    issue(C_MUL_W, 32'd2, 32'd3, 5'd3, 1'b1, 32'd6, 3);
    wait_done("after_drain");

    wb_ready = 1'b0;
    issue(C_MUL_W, 32'd8, 32'd8, 5'd4, 1'b0, 32'd0, 0);
    wait_wb_valid("hold_valid_seen");
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_hold_valid", 64'(wb_valid), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    chk("flush_hold_idle", 64'(busy), 64'd0);
    chk("flush_hold_valid2", 64'(wb_valid), 64'd0);

    mul_lat = 2;
    w0 = wb_cnt;
    issue(C_MUL_W, 32'd9, 32'd9, 5'd5, 1'b0, 32'd0, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_wait_busy", 64'(busy), 64'd0);
    chk("rst_wait_ready", 64'(op_ready), 64'd1);
    chk("rst_wait_reg1", 64'(mul_reg1), 64'd0);
    @(negedge clk);
    chk("rst_stray_busy", 64'(busy), 64'd0);
    chk("rst_stray_valid", 64'(wb_valid), 64'd0);
    chk("rst_stray_ready", 64'(op_ready), 64'd1);
    chk("rst_no_wb", 64'(wb_cnt - w0), 64'd0);
    mul_lat = 1;
    issue(C_MUL_W, 32'd10, 32'd11, 5'd6, 1'b1, 32'd110, 3);
    wait_done("after_reset");

`ifdef MUL_REUSE_EN
    issue(C_MULH_W, 32'd7, 32'd9, 5'd7, 1'b1, 32'd0, 3);
    wait_done("reuse_first");
    s0 = start_cnt;
    issue(C_MUL_W, 32'd7, 32'd9, 5'd8, 1'b1, 32'd63, 1);
    wait_done("reuse_hit");
    chk("reuse_hit_nstart", 64'(start_cnt - s0), 64'd0);
    issue(C_MULH_WU, 32'd7, 32'd9, 5'd9, 1'b1, 32'd0, 3);
    wait_done("reuse_miss");
    chk("reuse_miss_start", 64'(start_cnt - s0), 64'd1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
